noc_out_arbiter: RTL and testbench

- Wormhole output-port arbiter for one router output (NORTH/SOUTH/EAST/WEST/local).
- Shares the single output flit channel among N_IN input ports. A packet's HEADER flit wins a round-robin grant, and the grant stays locked until that packet's TAIL flit transfers.
- Sits between the per-input buffers and the output link register. All flits are flit_t; valid/ready handshake on both sides.

---
 rtl/noc_out_arbiter_pkg.sv | 34 +++
 rtl/noc_out_arbiter_rr_pick.sv | 39 +++
 rtl/noc_out_arbiter.sv | 153 +++++++++++++++
 tb/tb_noc_out_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_out_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : noc_out_arbiter_pkg
// Brief  : Flit format, arbiter state encoding and router-wide constants.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package noc_out_arbiter_pkg;

    localparam int N_ROUTER_PORTS = 5;
    localparam int FLIT_DATA_W    = 32;

    typedef enum logic [1:0] {
        DATA     = 2'b00,
        HEADER   = 2'b01,
        TAIL     = 2'b10,
        RESERVED = 2'b11
    } e_flit;

    typedef struct packed {
        e_flit                  ftype;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    localparam int FLIT_WIDTH = $bits(flit_t);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } e_arb_state;

endpackage

`default_nettype wire

// File: rtl/noc_out_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// Module : noc_out_arbiter_rr_pick
// Brief  : Combinational round-robin picker: first request at or after i_ptr.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module noc_out_arbiter_rr_pick #(
    parameter int N_IN  = 5,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_any,
    output logic [IDX_W-1:0] o_winner
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Scan from the far end back toward i_ptr so the nearest request wins last.
    always_comb begin
        o_any    = |i_req;
        o_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_IN))
                w_sum = w_sum - (IDX_W+1)'(N_IN);
            w_idx = w_sum[IDX_W-1:0];
            if (i_req[w_idx])
                o_winner = w_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_out_arbiter.sv
//------------------------------------------------------------------------------
// Module : noc_out_arbiter
// Brief  : Wormhole output-port arbiter; HEADER wins round-robin, TAIL unlocks.
//          Optional protocol checker enabled by NOC_ARB_PROTO_CHECK_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module noc_out_arbiter
    import noc_out_arbiter_pkg::*;
#(
    parameter int N_IN  = N_ROUTER_PORTS,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_IN-1:0]            i_in_valid,
    input  logic [N_IN*FLIT_WIDTH-1:0] i_in_flit,
    output logic [N_IN-1:0]            o_in_ready,
    output logic                       o_out_valid,
    output logic [FLIT_WIDTH-1:0]      o_out_flit,
    input  logic                       i_out_ready,
    output logic [IDX_W-1:0]           o_owner,
    output logic                       o_locked,
    output logic                       o_proto_err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;

    flit_t            w_flit [N_IN];
    logic [N_IN-1:0]  w_hdr_req;
    logic             w_any;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_next_ptr;
    flit_t            w_sel_flit;
    logic             w_sel_valid;
    logic             w_is_locked;
    logic             w_xfer;
    logic             w_tail_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_unpack
            assign w_flit[gi]     = flit_t'(i_in_flit[gi*FLIT_WIDTH +: FLIT_WIDTH]);
            assign w_hdr_req[gi]  = i_in_valid[gi] && (w_flit[gi].ftype == HEADER);
            // in_ready depends only on lock state and out_ready, never on in_valid.
            assign o_in_ready[gi] = w_is_locked && (r_owner == IDX_W'(gi)) && i_out_ready;
        end
    endgenerate

    noc_out_arbiter_rr_pick #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (w_hdr_req),
        .i_ptr    (r_rr_ptr),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    assign w_next_ptr = (w_winner == IDX_W'(N_IN - 1)) ? '0 : w_winner + 1'b1;

    always_comb begin
        w_sel_flit  = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_sel_flit  = w_flit[i];
                w_sel_valid = i_in_valid[i];
            end
        end
    end

    assign w_is_locked = (r_state == ST_LOCKED);
    assign o_out_valid = w_is_locked && w_sel_valid;
    assign o_out_flit  = w_sel_flit;
    assign w_xfer      = o_out_valid && i_out_ready;
    assign w_tail_xfer = w_xfer && (w_sel_flit.ftype == TAIL);
    assign o_owner     = r_owner;
    assign o_locked    = w_is_locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state  <= ST_LOCKED;
                        r_owner  <= w_winner;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: begin
                    if (w_tail_xfer)
                        r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef NOC_ARB_PROTO_CHECK_EN
    logic            r_proto_err;
    logic            r_first;
    logic [N_IN-1:0] w_bad_idle;
    logic            w_err_now;

    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_bad_idle
            assign w_bad_idle[gi] = i_in_valid[gi] && (w_flit[gi].ftype != HEADER);
        end
    endgenerate

    // r_first marks that the granted HEADER has not yet left the arbiter.
    assign w_err_now = (!w_is_locked && (|w_bad_idle)) ||
                       (w_xfer && (w_sel_flit.ftype == HEADER) && !r_first);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
            r_first     <= 1'b0;
        end else begin
            if (w_err_now)
                r_proto_err <= 1'b1;
            if (!w_is_locked && w_any)
                r_first <= 1'b1;
            else if (w_xfer)
                r_first <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && w_err_now)
            $error("noc_out_arbiter: flit protocol violation");
    end
`endif

    assign o_proto_err = r_proto_err;
`else
    assign o_proto_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_out_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_noc_out_arbiter
// Brief  : Scoreboard bench for noc_out_arbiter with directed packet scenarios.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_noc_out_arbiter;
    import noc_out_arbiter_pkg::*;

    localparam int N  = 5;
    localparam int IW = 3;
    localparam int FW = FLIT_WIDTH;

    typedef struct packed {
        logic [IW-1:0] owner;
        logic [FW-1:0] flit;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      in_valid;
    logic [N*FW-1:0]   in_flit;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [FW-1:0]     out_flit;
    logic              out_ready;
    logic [IW-1:0]     owner;
    logic              locked;
    logic              proto_err;

    logic [FW-1:0]     src_q [N][$];
    exp_t              sb_q [$];
    logic [N-1:0]      fire;
    logic              ordy_cmd = 1'b1;
    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;
    int                first_xfer = -1;
    int                last_xfer = -1;

    always #5 clk = ~clk;

    noc_out_arbiter #(.N_IN(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .i_in_flit   (in_flit),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_out_flit  (out_flit),
        .i_out_ready (out_ready),
        .o_owner     (owner),
        .o_locked    (locked),
        .o_proto_err (proto_err)
    );

    function automatic logic [FW-1:0] pkt_flit(input int src, input int n, input int id, input int k);
        flit_t f;
        if (k == 0)          f.ftype = HEADER;
        else if (k == n - 1) f.ftype = TAIL;
        else if (id == 22)   f.ftype = RESERVED;
        else                 f.ftype = DATA;
        f.data = {8'(id), 8'(src), 16'(k)};
        return f;
    endfunction

    task automatic send_pkt(input int src, input int n, input int id);
        for (int k = 0; k < n; k++) src_q[src].push_back(pkt_flit(src, n, id, k));
    endtask

    task automatic expect_pkt(input int src, input int n, input int id);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.owner = IW'(src);
            e.flit  = pkt_flit(src, n, id, k);
            sb_q.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s timeout pending=%0d expected=0", name, sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb_q.delete();
    endtask

    // Source driver: consume on handshake seen mid-cycle, re-present after the edge.
    initial begin
        in_valid  = '0;
        in_flit   = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            fire = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && rst_n && src_q[i].size() > 0) void'(src_q[i].pop_front());
                in_valid[i]           = (src_q[i].size() > 0);
                in_flit[i*FW +: FW]   = (src_q[i].size() > 0) ? src_q[i][0] : '0;
            end
            out_ready = ordy_cmd;
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && out_valid && out_ready) begin
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got owner=%0d flit=%h expected none", owner, out_flit);
                end else begin
                    e = sb_q.pop_front();
                    if ({owner, out_flit} !== {e.owner, e.flit}) begin
                        failures++;
                        $display("FAIL sb_flit got owner=%0d flit=%h expected owner=%0d flit=%h",
                                 owner, out_flit, e.owner, e.flit);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        logic [FW-1:0] held;

        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_locked", locked, 0);
        chk("reset_owner", owner, 0);
        chk("reset_proto_err", proto_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single packet on input 2.
        send_pkt(2, 4, 1);
        expect_pkt(2, 4, 1);
        @(negedge clk);
        chk("t1_no_xfer_in_idle", out_valid, 0);
        chk("t1_not_locked_yet", locked, 0);
        @(negedge clk);
        chk("t1_locked", locked, 1);
        chk("t1_owner", owner, 2);
        vcnt = 0;
        for (int k = 0; k < 4; k++) begin
            vcnt += int'(out_valid);
            @(negedge clk);
        end
        chk("t1_valid_run", vcnt, 4);
        chk("t1_idle_after_tail", locked, 0);
        wait_drain("t1_drain", 20);

        // Contention from reset: inputs 0, 1, 4.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pkt(0, 3, 10);
        send_pkt(1, 2, 11);
        send_pkt(4, 3, 12);
        expect_pkt(0, 3, 10);
        expect_pkt(1, 2, 11);
        expect_pkt(4, 3, 12);
        first_xfer = -1;
        wait_drain("t2_drain", 60);
        chk("t2_span_with_gaps", last_xfer - first_xfer + 1, 10);

        // Wrap-around: move rr_ptr to 4, then requests on 1 and 3.
        send_pkt(3, 2, 20);
        expect_pkt(3, 2, 20);
        wait_drain("t3a_drain", 20);
        send_pkt(1, 2, 21);
        send_pkt(3, 3, 22);
        expect_pkt(1, 2, 21);
        expect_pkt(3, 3, 22);
        wait_drain("t3b_drain", 40);

        // Backpressure with rr_ptr=4: input 4 wins over pending input 3.
        send_pkt(4, 4, 30);
        send_pkt(3, 2, 31);
        expect_pkt(4, 4, 30);
        expect_pkt(3, 2, 31);
        repeat (2) @(negedge clk);
        chk("t4_owner_grant", owner, 4);
        ordy_cmd = 1'b0;
        held = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) held = out_flit;
            chk("t4_flit_stable", out_flit, held);
            chk("t4_in_ready_zero", in_ready, 0);
            chk("t4_owner_held", owner, 4);
            chk("t4_locked_held", locked, 1);
            if (k == 4) ordy_cmd = 1'b1;
        end
        chk("t4_held_is_data1", held, pkt_flit(4, 4, 30, 1));
        wait_drain("t4_drain", 40);

        // Reset mid-packet.
        send_pkt(2, 4, 40);
        expect_pkt(2, 4, 40);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_locked", locked, 0);
        chk("t5_rst_owner", owner, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        clear_queues();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_pkt(0, 2, 41);
        expect_pkt(0, 2, 41);
        repeat (2) @(negedge clk);
        chk("t5_fresh_locked", locked, 1);
        chk("t5_fresh_owner", owner, 0);
        wait_drain("t5_drain", 20);

        // DATA flit on input 1 while idle.
        src_q[1].push_back(pkt_flit(1, 3, 50, 1));
        repeat (2) @(negedge clk);
`ifdef NOC_ARB_PROTO_CHECK_EN
        chk("t6_proto_err_set", proto_err, 1);
        repeat (3) @(negedge clk);
        chk("t6_proto_err_sticky", proto_err, 1);
`else
        for (int k = 0; k < 4; k++) begin
            chk("t6_proto_err_zero", proto_err, 0);
            chk("t6_stall_not_locked", locked, 0);
            chk("t6_stall_in_ready", in_ready[1], 0);
            @(negedge clk);
        end
`endif
        rst_n = 1'b0;
        clear_queues();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
